// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// Module   : median_pkg
// Brief    : Shared constants for the median actor pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
package median_pkg;

  localparam int BUFF_SIZE_DEF     = 1024;
  localparam int BUFF_SIZE_BIT_DEF = $clog2(BUFF_SIZE_DEF) + 1;

  localparam logic [1:0] CLS_LOW  = 2'b00;
  localparam logic [1:0] CLS_EQ   = 2'b01;
  localparam logic [1:0] CLS_LARG = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] RST_PIVOT         = 8'd127;
  localparam logic [7:0] RST_SECOND_MEDIAN = 8'd127;
  localparam logic [8:0] INIT_MAX          = 9'd0;
  localparam logic [8:0] INIT_MIN          = 9'd255;

  function automatic logic [1:0] classify(input logic [7:0] value, input logic [7:0] pivot);
    if (value < pivot)
      return CLS_LOW;
    else if (value == pivot)
      return CLS_EQ;
    else
      return CLS_LARG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/partition_stats_minmax.sv
`default_nettype none
// ============================================================================
// Module   : minmax_tracker
// Brief    : Running min/max of an 8-bit stream, zero-extended to 9 bits.
// Revision : 1.0 - initial release
// ============================================================================
module minmax_tracker
  import median_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [7:0] i_value,
  output logic [8:0] o_max,
  output logic [8:0] o_min
);

  logic [8:0] r_max;
  logic [8:0] r_min;
  logic [8:0] w_value;

  assign w_value = {1'b0, i_value};

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_max <= INIT_MAX;
      r_min <= INIT_MIN;
    end else if (i_en) begin
      if (w_value > r_max) r_max <= w_value;
      if (w_value < r_min) r_min <= w_value;
    end
  end

  assign o_max = r_max;
  assign o_min = r_min;

endmodule
`default_nettype wire

// File: rtl/partition_stats.sv
`default_nettype none
// ============================================================================
// Module   : partition_stats
// Brief    : Classifies a buffer of samples against a pivot, counts partitions
//            and tracks lower/larger extremes for the next-pivot stage.
// Revision : 1.0 - initial release
// ============================================================================
module partition_stats
  import median_pkg::*;
#(
  parameter int BUFF_SIZE     = BUFF_SIZE_DEF,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_pivot,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
  input  logic [7:0]               in_second_median_value,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_data,
  output logic [1:0]               out_class,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     up_next,
  output logic [BUFF_SIZE_BIT-1:0] lower_size,
  output logic [BUFF_SIZE_BIT-1:0] equal_size,
  output logic [BUFF_SIZE_BIT-1:0] larger_size,
  output logic [8:0]               max_lower,
  output logic [8:0]               min_lower,
  output logic [8:0]               max_larger,
  output logic [8:0]               min_larger,
  output logic [8:0]               in_pivot_samp,
  output logic [BUFF_SIZE_BIT-1:0] in_buff_size_samp,
  output logic [BUFF_SIZE_BIT-1:0] in_median_pos_samp,
  output logic [8:0]               in_second_median_value_samp
);

  localparam logic [BUFF_SIZE_BIT-1:0] SIZE_MAX = BUFF_SIZE_BIT'(BUFF_SIZE);
  localparam logic [BUFF_SIZE_BIT-1:0] SIZE_MID = BUFF_SIZE_BIT'(BUFF_SIZE / 2);
  localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);

  logic [1:0]               r_state;
  logic [7:0]               r_pivot;
  logic [7:0]               r_second;
  logic [BUFF_SIZE_BIT-1:0] r_buff_size;
  logic [BUFF_SIZE_BIT-1:0] r_median_pos;
  logic [BUFF_SIZE_BIT-1:0] r_lower;
  logic [BUFF_SIZE_BIT-1:0] r_equal;
  logic [BUFF_SIZE_BIT-1:0] r_larger;
  logic [7:0]               r_out_data;
  logic [1:0]               r_out_class;
  logic                     r_out_valid;

  logic                     w_start;
  logic                     w_xfer;
  logic [1:0]               w_cls;
  logic [BUFF_SIZE_BIT-1:0] w_total_next;
  logic [BUFF_SIZE_BIT-1:0] w_size_sat;

  assign w_start      = (r_state == ST_IDLE) && start;
  assign w_xfer       = (r_state == ST_RUN) && in_valid;
  assign w_cls        = classify(in_data, r_pivot);
  assign w_total_next = r_lower + r_equal + r_larger + ONE;
  assign w_size_sat   = (in_buff_size > SIZE_MAX) ? SIZE_MAX : in_buff_size;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pivot      <= RST_PIVOT;
      r_second     <= RST_SECOND_MEDIAN;
      r_buff_size  <= SIZE_MAX;
      r_median_pos <= SIZE_MID;
      r_lower      <= '0;
      r_equal      <= '0;
      r_larger     <= '0;
      r_out_data   <= '0;
      r_out_class  <= CLS_LOW;
      r_out_valid  <= 1'b0;
    end else begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data  <= in_data;
        r_out_class <= w_cls;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pivot      <= in_pivot;
            r_second     <= in_second_median_value;
            r_buff_size  <= w_size_sat;
            r_median_pos <= in_median_pos;
            r_lower      <= '0;
            r_equal      <= '0;
            r_larger     <= '0;
            r_state      <= (in_buff_size == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            case (w_cls)
              CLS_LOW: r_lower  <= r_lower + ONE;
              CLS_EQ:  r_equal  <= r_equal + ONE;
              default: r_larger <= r_larger + ONE;
            endcase
            // The last sample lands in the same cycle as up_next via out_valid.
            if (w_total_next == r_buff_size) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  minmax_tracker u_lower (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_en    (w_xfer && (w_cls == CLS_LOW)),
    .i_value (in_data),
    .o_max   (max_lower),
    .o_min   (min_lower)
  );

  minmax_tracker u_larger (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_en    (w_xfer && (w_cls == CLS_LARG)),
    .i_value (in_data),
    .o_max   (max_larger),
    .o_min   (min_larger)
  );

  assign in_ready                    = (r_state == ST_RUN);
  assign busy                        = (r_state != ST_IDLE);
  assign up_next                     = (r_state == ST_DONE);
  assign out_data                    = r_out_data;
  assign out_class                   = r_out_class;
  assign out_valid                   = r_out_valid;
  assign lower_size                  = r_lower;
  assign equal_size                  = r_equal;
  assign larger_size                 = r_larger;
  assign in_pivot_samp               = {1'b0, r_pivot};
  assign in_buff_size_samp           = r_buff_size;
  assign in_median_pos_samp          = r_median_pos;
  assign in_second_median_value_samp = {1'b0, r_second};

endmodule
`default_nettype wire

// File: tb/tb_partition_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_partition_stats
// Brief    : Scoreboard bench for partition_stats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_partition_stats;

  localparam int BS  = 1024;
  localparam int BSB = 11;

  logic           clk = 1'b0;
  logic           rst, start, in_valid, in_ready, out_valid, busy, up_next;
  logic [7:0]     in_pivot, in_second_median_value, in_data, out_data;
  logic [BSB-1:0] in_buff_size, in_median_pos;
  logic [1:0]     out_class;
  logic [BSB-1:0] lower_size, equal_size, larger_size;
  logic [8:0]     max_lower, min_lower, max_larger, min_larger;
  logic [8:0]     in_pivot_samp, in_second_median_value_samp;
  logic [BSB-1:0] in_buff_size_samp, in_median_pos_samp;

  partition_stats #(.BUFF_SIZE(BS), .BUFF_SIZE_BIT(BSB)) dut (
    .clk(clk), .rst(rst), .start(start), .in_pivot(in_pivot),
    .in_buff_size(in_buff_size), .in_median_pos(in_median_pos),
    .in_second_median_value(in_second_median_value),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_class(out_class), .out_valid(out_valid),
    .busy(busy), .up_next(up_next),
    .lower_size(lower_size), .equal_size(equal_size), .larger_size(larger_size),
    .max_lower(max_lower), .min_lower(min_lower),
    .max_larger(max_larger), .min_larger(min_larger),
    .in_pivot_samp(in_pivot_samp), .in_buff_size_samp(in_buff_size_samp),
    .in_median_pos_samp(in_median_pos_samp),
    .in_second_median_value_samp(in_second_median_value_samp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo, eq, lg, maxl, minl, maxg, ming, piv, bsz, mpos, smv, lat;
  } stats_t;

  stats_t     exp_stats_q[$];
  logic [9:0] exp_fwd_q[$];
  logic [7:0] smp[$];
  bit         vld[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output-side scoreboard: forwarded samples and end-of-pass statistics.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_fwd_q.size() == 0) check("fwd_unexpected", 1, 0);
      else begin
        logic [9:0] e;
        e = exp_fwd_q.pop_front();
        check("out_data", out_data, e[7:0]);
        check("out_class", out_class, e[9:8]);
      end
    end
    if (up_next) begin
      if (exp_stats_q.size() == 0) check("up_unexpected", 1, 0);
      else begin
        stats_t s;
        s = exp_stats_q.pop_front();
        check("lower_size", lower_size, s.lo);
        check("equal_size", equal_size, s.eq);
        check("larger_size", larger_size, s.lg);
        check("max_lower", max_lower, s.maxl);
        check("min_lower", min_lower, s.minl);
        check("max_larger", max_larger, s.maxg);
        check("min_larger", min_larger, s.ming);
        check("pivot_samp", in_pivot_samp, s.piv);
        check("buff_size_samp", in_buff_size_samp, s.bsz);
        check("median_pos_samp", in_median_pos_samp, s.mpos);
        check("second_samp", in_second_median_value_samp, s.smv);
        check("latency", cyc - start_cyc, s.lat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_up_next", up_next, 0);
    check("rst_counts", {lower_size, equal_size, larger_size}, 0);
    check("rst_max", {max_lower, max_larger}, 0);
    check("rst_min_lower", min_lower, 255);
    check("rst_min_larger", min_larger, 255);
    check("rst_pivot_samp", in_pivot_samp, 127);
    check("rst_buff_size_samp", in_buff_size_samp, BS);
    check("rst_median_pos_samp", in_median_pos_samp, BS / 2);
    check("rst_second_samp", in_second_median_value_samp, 127);
  endtask

  task automatic do_pass(input logic [7:0] piv, input int size, input int mp,
                         input int smv, input bit noise);
    stats_t e;
    int eff, k, c;
    bit v;
    eff = (size > BS) ? BS : size;
    e = '{lo: 0, eq: 0, lg: 0, maxl: 0, minl: 255, maxg: 0, ming: 255,
          piv: piv, bsz: eff, mpos: mp, smv: smv, lat: 0};
    for (int i = 0; i < eff; i++) begin
      int s;
      s = smp[i];
      if (s < piv) begin
        e.lo++; if (s > e.maxl) e.maxl = s; if (s < e.minl) e.minl = s;
      end else if (s == piv) e.eq++;
      else begin
        e.lg++; if (s > e.maxg) e.maxg = s; if (s < e.ming) e.ming = s;
      end
    end
    k = 0; c = 0;
    while (k < eff) begin
      v = (c < vld.size()) ? vld[c] : 1'b1;
      if (v) k++;
      c++;
    end
    e.lat = c + 1;
    exp_stats_q.push_back(e);

    in_pivot = piv; in_buff_size = BSB'(size); in_median_pos = BSB'(mp);
    in_second_median_value = 8'(smv); start = 1'b1; start_cyc = cyc;
    check("ready_idle", in_ready, 0);
    step();
    start = 1'b0;
    if (noise) begin
      start = 1'b1; in_pivot = ~piv; in_buff_size = BSB'(7);
    end
    k = 0; c = 0;
    while (k < eff) begin
      check("ready_run", in_ready, 1);
      v = (c < vld.size()) ? vld[c] : 1'b1;
      in_valid = v;
      in_data = v ? smp[k] : 8'($urandom_range(0, 255));
      if (v) begin
        logic [1:0] cl;
        cl = (smp[k] < piv) ? 2'b00 : (smp[k] == piv) ? 2'b01 : 2'b11;
        exp_fwd_q.push_back({cl, smp[k]});
        k++;
      end
      step();
      c++;
    end
    in_valid = 1'b0;
    check("ready_done", in_ready, 0);
    check("up_next_pulse", up_next, 1);
    step();
    start = 1'b0;
    check("busy_idle", busy, 0);
    check("up_next_single", up_next, 0);
    check("stats_hold", {lower_size, equal_size, larger_size},
          {BSB'(e.lo), BSB'(e.eq), BSB'(e.lg)});
    check("stats_q_drained", exp_stats_q.size(), 0);
    check("fwd_q_drained", exp_fwd_q.size(), 0);
    exp_stats_q.delete();
    exp_fwd_q.delete();
    vld.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    in_pivot = '0; in_buff_size = '0; in_median_pos = '0; in_second_median_value = '0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_state();

    smp = '{50, 100, 150, 20};
    do_pass(8'd100, 4, 2, 33, 1'b0);

    smp = '{100, 100, 100};
    do_pass(8'd100, 3, 1, 90, 1'b0);

    smp.delete();
    do_pass(8'd42, 0, 0, 5, 1'b0);

    smp = '{10, 200, 7};
    vld = '{1, 0, 0, 1, 1};
    do_pass(8'd9, 3, 1, 200, 1'b0);

    // Reset two samples into a four-sample pass.
    in_pivot = 8'd100; in_buff_size = BSB'(4); in_median_pos = BSB'(2);
    in_second_median_value = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd5;   exp_fwd_q.push_back({2'b00, 8'd5});
    step();
    in_data = 8'd200;                  exp_fwd_q.push_back({2'b11, 8'd200});
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state();
    smp = '{3, 250};
    do_pass(8'd128, 2, 1, 77, 1'b0);

    smp = '{60, 61, 59, 0, 255};
    vld = '{1, 0, 1, 1, 0, 1, 1};
    do_pass(8'd60, 5, 3, 61, 1'b1);

    // Oversized pass length saturates to the buffer capacity.
    in_buff_size = BSB'(2000); in_pivot = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    check("size_saturate", in_buff_size_samp, BS);
    check("busy_run", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("busy_after_rst", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/partition_stats.md
Name: partition_stats

Overview:
- Upstream neighbour of the next-pivot logic in each median actor.
- Streams one buffer of 8-bit samples, classifies each sample against the current pivot (lower / equal / larger) and counts each partition.
- Tracks the min and max of the lower and larger partitions, and forwards each sample with its class tag to the partition buffer writer.
- When the buffer is exhausted, raises up_next for one cycle with stable statistics, which the next-pivot stage consumes.

Parameters:
- BUFF_SIZE, 1024, maximum samples per pass.
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of every size/position field (11 at default).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- in_pivot  in  8  pivot for this pass.
- in_buff_size  in  BUFF_SIZE_BIT  number of samples in this pass.
- in_median_pos  in  BUFF_SIZE_BIT  median position, passed through.
- in_second_median_value  in  8  passed through.
- in_data  in  8  sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- out_data  out  8  forwarded sample.
- out_class  out  2  00 lower, 01 equal, 11 larger.
- out_valid  out  1  forwarded-sample strobe; no backpressure.
- busy  out  1  high outside IDLE.
- up_next  out  1  one-cycle pulse; statistics valid.
- lower_size, equal_size, larger_size  out  BUFF_SIZE_BIT  partition counts.
- max_lower, min_lower, max_larger, min_larger  out  9  zero-extended extremes.
- in_pivot_samp  out  9  pivot latched at start, zero-extended.
- in_buff_size_samp, in_median_pos_samp  out  BUFF_SIZE_BIT  latched at start.
- in_second_median_value_samp  out  9  latched at start, zero-extended.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - On start: latch pivot, buff_size, median_pos and second_median_value.
  - Clear counts to 0; set max_* to 9'd0 and min_* to 9'd255.
  - Next state is RUN, or DONE if in_buff_size==0.
  - in_buff_size > BUFF_SIZE saturates to BUFF_SIZE.
- RUN:
  - in_ready=1.
  - On each transfer: if sample < pivot, increment lower_size and update min/max_lower; if equal, increment equal_size; if greater, increment larger_size and update min/max_larger.
  - Comparisons are unsigned 8-bit.
  - A transfer that makes lower+equal+larger == in_buff_size_samp moves to DONE on the next cycle.
  - in_valid low stalls without side effects.
- DONE:
  - Lasts one cycle; up_next=1, in_ready=0; return to IDLE.
- Forwarding: out_data, out_class and out_valid are registered; out_valid asserts exactly 1 cycle after each transfer.
- The final forwarded sample appears in the same cycle as up_next.
- Stats and *_samp outputs:
  - Registered and updated only in RUN (and cleared on start).
  - Stable from DONE until the next accepted start, so the next-pivot stage may sample them in the up_next cycle.
- Latency: N samples with no stalls → up_next at cycle N+1 after the start cycle.
- Empty partitions keep their init extremes (max 0, min 255); the consumer never selects them.
- start while busy is ignored. start in the DONE cycle is ignored; it is accepted next cycle in IDLE.
- rst mid-pass:
  - Next cycle IDLE; in_ready, out_valid, up_next and busy all 0; counts 0.
  - max_* 0, min_* 255.
  - in_pivot_samp 127, in_buff_size_samp BUFF_SIZE, in_median_pos_samp BUFF_SIZE/2, second_median 127.
- Counters never exceed in_buff_size_samp; no wrap is possible.

Decomposition:
- Shared package (median_pkg):
  - BUFF_SIZE / BUFF_SIZE_BIT defaults.
  - Class encodings CLS_LOW=2'b00, CLS_EQ=2'b01, CLS_LARG=2'b11.
  - FSM state constants.
  - Reset constants: pivot 127, second median 127.
- One natural sub-module: minmax_tracker (clear, en, 8-bit value → 9-bit min/max), instanced twice (lower, larger).

Test Plan:
- pivot=100, size=4, samples 50,100,150,20, no stalls:
  - lower=2, equal=1, larger=1; min/max_lower=20/50; min/max_larger=150/150.
  - out_class sequence 00,01,11,00; up_next at cycle 5 after start.
- size=3, all samples=100, pivot=100:
  - equal=3; max_lower=0, min_lower=255; larger extremes unchanged.
- size=0: up_next the cycle after start; all counts 0; in_ready never high.
- in_valid toggled 1,0,0,1,1 with size=3: up_next exactly 1 cycle after the third transfer; no count change on stall cycles.
- rst asserted after 2 of 4 samples: next cycle IDLE with counts 0 and in_ready=0. A fresh start with size=2 then completes correctly.
- start pulsed during RUN and during DONE: both ignored; stats unchanged until the next IDLE start.
